// File: rtl/video_sync_gen.sv
// ---------------------------------------------------------------------------
// video_sync_gen
//
// Character-granular timing generator for the 800x600@60 Hz output path.
// One char_clock = 8 pixels. The horizontal and vertical counters step
// through a full frame, including the blanking positions. Two decodes come
// with the counters:
//   - pre_visible / frame_tick are registered from the next-state counters,
//     so they describe the counter values present in the same cycle.
//   - hsync / vsync are registered from the current counters, so they are
//     one clock late. This matches the render stage's registered colour
//     output.
// Every output comes straight from a flop. vsync also clocks downstream
// motion logic, so it must never glitch.
//
// This block has no handshake. The outputs are a free-running stream that
// is valid on every clock once reset has been sampled.
//
// Ports:
//   char_clock   in   character clock, the only clock
//   reset        in   synchronous, active-high reset
//   char_count   out  [7:0]  horizontal character position, 0..H_TOTAL-1
//   line_count   out  [11:0] vertical line position, 0..V_TOTAL-1
//   pre_visible  out  current (char_count, line_count) is in the active area
//   hsync        out  horizontal sync, one clock behind the counters
//   vsync        out  vertical sync, one clock behind the counters
//   frame_tick   out  one-clock pulse while the counters are at (0,0)
// ---------------------------------------------------------------------------
module video_sync_gen #(
    parameter int   H_VISIBLE  = 100,
    parameter int   H_FRONT    = 5,
    parameter int   H_SYNC     = 16,
    parameter int   H_BACK     = 11,
    parameter int   V_VISIBLE  = 600,
    parameter int   V_FRONT    = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BACK     = 23,
    parameter logic H_SYNC_POL = 1'b1,
    parameter logic V_SYNC_POL = 1'b1
) (
    input  logic        char_clock,
    input  logic        reset,
    output logic [7:0]  char_count,
    output logic [11:0] line_count,
    output logic        pre_visible,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counter-width constants. The elaboration checks below make sure
    // these casts never truncate.
    localparam logic [7:0]  H_MAX      = 8'(H_TOTAL - 1);
    localparam logic [7:0]  H_VIS      = 8'(H_VISIBLE);
    localparam logic [7:0]  H_SYNC_BEG = 8'(H_VISIBLE + H_FRONT);
    localparam logic [7:0]  H_SYNC_END = 8'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] V_MAX      = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] V_SYNC_END = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Elaboration-time guards on the geometry.
    if (H_TOTAL > 256) begin : g_bad_h_total
        $error("video_sync_gen: H_TOTAL exceeds the 8-bit char_count range");
    end
    if (V_TOTAL > 4096) begin : g_bad_v_total
        $error("video_sync_gen: V_TOTAL exceeds the 12-bit line_count range");
    end
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_h_porch
        $error("video_sync_gen: horizontal porch/sync widths must be non-zero");
    end
    if (V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_v_porch
        $error("video_sync_gen: vertical porch/sync widths must be non-zero");
    end

    logic        h_wrap;
    logic [7:0]  char_next;
    logic [11:0] line_next;
    logic        pre_visible_next;
    logic        frame_tick_next;
    logic        hsync_active;
    logic        vsync_active;

    always_comb begin
        h_wrap           = (char_count == H_MAX);
        char_next        = char_count + 8'd1;
        line_next        = line_count;
        pre_visible_next = 1'b0;
        frame_tick_next  = 1'b0;
        hsync_active     = 1'b0;
        vsync_active     = 1'b0;

        if (h_wrap) begin
            char_next = '0;
            // The line only advances on the horizontal wrap. At the last
            // line, both counters wrap together and land on (0,0).
            if (line_count == V_MAX) begin
                line_next = '0;
            end else begin
                line_next = line_count + 12'd1;
            end
        end

        // Decoded from the next-state counters so that, once registered,
        // each flag lines up with the counters it describes.
        pre_visible_next = (char_next < H_VIS) && (line_next < V_VIS);
        frame_tick_next  = (char_next == '0) && (line_next == '0);

        // Decoded from the current counters. This makes the registered sync
        // one clock late, which matches the render stage's output register.
        hsync_active = (char_count >= H_SYNC_BEG) && (char_count <= H_SYNC_END);
        vsync_active = (line_count >= V_SYNC_BEG) && (line_count <= V_SYNC_END);
    end

    always_ff @(posedge char_clock) begin
        if (reset) begin
            // Park on the last blanking position. The first clock after
            // release then lands cleanly on (0,0).
            char_count  <= H_MAX;
            line_count  <= V_MAX;
            pre_visible <= 1'b0;
            frame_tick  <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
        end else begin
            char_count  <= char_next;
            line_count  <= line_next;
            pre_visible <= pre_visible_next;
            frame_tick  <= frame_tick_next;
            hsync       <= hsync_active ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= vsync_active ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
// ---------------------------------------------------------------------------
// Bench for video_sync_gen.
// Instance a: default polarity. It runs one clean frame after reset.
// Instance b: inverted polarity. It takes a one-clock reset at (57,300),
// another while hsync is active, and then random one-clock resets.
// The reference model tracks one linear position per instance, counted in
// clocks since frame start. Counters, decodes and sync windows are all
// derived from that position with division and modulo.
// ---------------------------------------------------------------------------
module tb_video_sync_gen;

  localparam int HV = 100, HF = 5, HS = 16, HB = 11;
  localparam int VV = 600, VF = 1, VS = 4, VB = 23;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int W = 24;

  logic        char_clock = 1'b0;
  logic        reset_a, reset_b;
  logic [7:0]  char_a, char_b;
  logic [11:0] line_a, line_b;
  logic        pv_a, pv_b, hs_a, hs_b, vs_a, vs_b, ft_a, ft_b;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [2*W-1:0] exp_q[$];

  // model state
  int   a_pos, b_pos;
  logic a_hs, a_vs, b_hs, b_vs;

  // frame statistics for instance a
  int   a_ticks = 0;
  int   a_interval = 0;
  int   a_hrises = 0;
  int   a_vhigh = 0;
  logic a_hs_prev = 1'b0;

  video_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_a (
    .char_clock(char_clock), .reset(reset_a),
    .char_count(char_a), .line_count(line_a), .pre_visible(pv_a),
    .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
  );

  video_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_b (
    .char_clock(char_clock), .reset(reset_b),
    .char_count(char_b), .line_count(line_b), .pre_visible(pv_b),
    .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
  );

  // ---------------- clock ----------------
  always #5 char_clock = ~char_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_edge(input logic r, inout int pos, inout logic hs, inout logic vs);
    int ch;
    int ln;
    if (r) begin
      pos = FRAME - 1;
      hs  = 1'b0;
      vs  = 1'b0;
    end else begin
      ch  = pos % HT;
      ln  = pos / HT;
      hs  = (ch >= HV + HF) && (ch < HV + HF + HS);
      vs  = (ln >= VV + VF) && (ln < VV + VF + VS);
      pos = (pos + 1) % FRAME;
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int pos, input logic hs, input logic vs,
                                            input logic hpol, input logic vpol);
    int ch;
    int ln;
    logic pv;
    ch = pos % HT;
    ln = pos / HT;
    pv = (ch < HV) && (ln < VV);
    return {8'(ch), 12'(ln), pv, hs ? hpol : ~hpol, vs ? vpol : ~vpol, pos == 0};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic ra, input logic rb);
    reset_a = ra;
    reset_b = rb;
    @(posedge char_clock);
    model_edge(ra, a_pos, a_hs, a_vs);
    model_edge(rb, b_pos, b_hs, b_vs);
    exp_q.push_back({exp_word(a_pos, a_hs, a_vs, 1'b1, 1'b1),
                     exp_word(b_pos, b_hs, b_vs, 1'b0, 1'b0)});
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] act, input logic [W-1:0] req);
    check({tag, ".char_count"},  32'(act[23:16]), 32'(req[23:16]));
    check({tag, ".line_count"},  32'(act[15:4]),  32'(req[15:4]));
    check({tag, ".pre_visible"}, 32'(act[3]),     32'(req[3]));
    check({tag, ".hsync"},       32'(act[2]),     32'(req[2]));
    check({tag, ".vsync"},       32'(act[1]),     32'(req[1]));
    check({tag, ".frame_tick"},  32'(act[0]),     32'(req[0]));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge char_clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_word("a", {char_a, line_a, pv_a, hs_a, vs_a, ft_a}, e[2*W-1:W]);
        check_word("b", {char_b, line_b, pv_b, hs_b, vs_b, ft_b}, e[W-1:0]);

        // whole-frame statistics on instance a
        if (ft_a === 1'b1) begin
          if (a_ticks > 0) begin
            check("frame_interval", 32'(a_interval), 32'(FRAME));
            check("hsync_pulses_per_frame", 32'(a_hrises), 32'(VT));
            check("vsync_high_clocks", 32'(a_vhigh), 32'(VS * HT));
          end
          a_ticks++;
          a_interval = 0;
          a_hrises   = 0;
          a_vhigh    = 0;
        end
        a_interval++;
        if (hs_a === 1'b1 && a_hs_prev !== 1'b1) a_hrises++;
        if (vs_a === 1'b1) a_vhigh++;
        a_hs_prev = hs_a;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic rb;
    bit   hit_mid;
    bit   hit_hs;
    hit_mid = 0;
    hit_hs  = 0;
    a_pos = FRAME - 1; b_pos = FRAME - 1;
    a_hs = 1'b0; a_vs = 1'b0; b_hs = 1'b0; b_vs = 1'b0;
    reset_a = 1'b1;
    reset_b = 1'b1;

    repeat (10) step(1'b1, 1'b1);

    for (int c = 0; c < FRAME + 4; c++) begin
      rb = 1'b0;
      if (!hit_mid && b_pos == 300 * HT + 57) begin
        rb = 1'b1;
        hit_mid = 1;
      end else if (hit_mid && !hit_hs && (b_pos % HT) == 110) begin
        rb = 1'b1;
        hit_hs = 1;
      end else if (hit_hs && $urandom_range(0, 2999) == 0) begin
        rb = 1'b1;
      end
      step(1'b0, rb);
    end

    @(negedge char_clock);
    @(negedge char_clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("frame_ticks_seen", 32'(a_ticks), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
- Character-granular video timing generator for the 800x600@60 Hz output path.
- Runs on the character clock, one clock = 8 pixels.
- Produces `char_count`, `line_count` and `pre_visible`, which the game/render stage decodes into registered colour bits.
- Also produces `hsync` and `vsync`, each delayed one clock so they align with that stage's registered video; `vsync` also clocks the game's motion logic.

Parameters:
- H_VISIBLE, 100, visible characters per line (800 px / 8)
- H_FRONT, 5, horizontal front porch in characters
- H_SYNC, 16, horizontal sync width in characters
- H_BACK, 11, horizontal back porch in characters (H_TOTAL = 132)
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch in lines
- V_SYNC, 4, vertical sync width in lines
- V_BACK, 23, vertical back porch in lines (V_TOTAL = 628)
- H_SYNC_POL, 1, active level of hsync
- V_SYNC_POL, 1, active level of vsync

Ports:
- char_clock  input  1  character clock, the only clock
- reset  input  1  synchronous, active-high reset
- char_count  output  8  horizontal character position, 0..H_TOTAL-1
- line_count  output  12  vertical line position, 0..V_TOTAL-1
- pre_visible  output  1  current (char_count, line_count) lies in the active area
- hsync  output  1  horizontal sync, one clock behind the counters
- vsync  output  1  vertical sync, one clock behind the counters
- frame_tick  output  1  one-clock pulse while the counters are at (0,0)

Behaviour:
- Reset: only edges of char_clock act, with reset sampled high.
  - Reset values: char_count = H_TOTAL-1, line_count = V_TOTAL-1, pre_visible = 0, frame_tick = 0.
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL.
  - This is the last blanking position, so all outputs are mutually consistent while reset is held.
- Reset release: the first clock with reset low moves the counters to (0,0), with pre_visible = 1 and frame_tick = 1.
- Reset mid-frame: takes effect on the next edge; there is no partial-line completion.
- Horizontal counter: increments every clock. At H_TOTAL-1 it wraps to 0 and line_count advances.
- Vertical counter: advances only on the horizontal wrap. At V_TOTAL-1, a simultaneous wrap of both counters lands on (0,0).
- Widths: counters never exceed H_TOTAL-1 / V_TOTAL-1.
  - Elaboration fails if H_TOTAL > 256 or V_TOTAL > 4096.
  - Elaboration fails if any porch/sync parameter is 0.
- Registered decode: pre_visible and frame_tick are registered from the next-state counter values, so they are valid in the same cycle as the counters they describe.
  - pre_visible = (char_count < H_VISIBLE) && (line_count < V_VISIBLE).
  - frame_tick = (char_count == 0) && (line_count == 0).
- Sync timing: hsync/vsync are registered from the current counter values, i.e. one clock late, matching the consumer's output register.
  - hsync is active when the delayed char_count is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 105..120 with defaults.
  - vsync is active when the delayed line_count is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 601..604.
  - vsync therefore changes one clock after char_count wraps to 0.
- Glitch-free outputs: all outputs come straight from flops, with no combinational path from inputs to outputs. vsync is used as a clock downstream, so this is mandatory.
- Frame length: exactly H_TOTAL*V_TOTAL = 82896 clocks (defaults) between frame_tick pulses.
- Sync pulse counts: exactly one hsync pulse per line and one vsync pulse per frame.

Test Plan:
- Reset held 10 clocks -> char_count = 131, line_count = 627, pre_visible = 0, hsync = 0, vsync = 0, frame_tick = 0 every cycle. First clock after release -> (0,0), pre_visible = 1, frame_tick = 1.
- Horizontal run on line 0 -> pre_visible 1 for char_count 0..99 and 0 for 100..131. hsync high for exactly 16 clocks, rising on the clock where char_count = 106. At char_count 131 -> 0, line_count increments to 1.
- Full frame -> frame_tick pulses every 82896 clocks. 628 hsync pulses per frame. vsync high for 4*132 = 528 clocks, first high in the cycle after the counters reach (0,601).
- Line 599 -> 600 boundary -> pre_visible stays 0 for the entire lines 600..627, including characters 0..99. Wrap (131,627) -> (0,0) re-asserts pre_visible.
- Reset asserted at (57,300) for one clock -> next cycle shows reset values. Following cycle shows (0,0) with frame_tick = 1. No hsync/vsync pulse is truncated into a runt: the active sync drops to inactive the cycle after reset is sampled.
- Polarity: H_SYNC_POL = 0, V_SYNC_POL = 0 -> reset levels are 1. Active pulse widths and positions are identical to the default case, inverted.
